// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: request/grant bundle between the memory-bus clients and mem_bus_arbiter
interface mem_bus_arbiter_if #(parameter int NUM_REQ = 4);
    localparam int OWNER_W = $clog2(NUM_REQ);
    logic [NUM_REQ-1:0] in_reqcyc;
    logic [NUM_REQ-1:0] in_bus_busy;
    logic [NUM_REQ-1:0] out_grant;
    logic [OWNER_W-1:0] out_owner;
    logic               out_owner_valid;
    logic               out_bus_busy;
    logic               out_proto_err;
    logic               out_timeout_err;
    modport slave (
        input  in_reqcyc, in_bus_busy,
        output out_grant, out_owner, out_owner_valid, out_bus_busy, out_proto_err, out_timeout_err
    );
    modport master (
        output in_reqcyc, in_bus_busy,
        input  out_grant, out_owner, out_owner_valid, out_bus_busy, out_proto_err, out_timeout_err
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin owner of the shared memory bus with a one-cycle turnaround.
// ARB_WATCHDOG_EN adds a MAX_HOLD-cycle ownership watchdog driving out_timeout_err.
module mem_bus_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int MAX_HOLD = 1024
) (
    input logic clk,
    input logic reset,
    mem_bus_arbiter_if.slave bus
);
    localparam int OWNER_W = $clog2(NUM_REQ);
    typedef enum logic [1:0] {IDLE, OWNED, TURNAROUND} state_t;
    state_t state, state_n;
    logic [NUM_REQ-1:0] grant, grant_n;
    logic [OWNER_W-1:0] owner, owner_n, rr_ptr, rr_n, sel, idx, nxt_owner;
    logic found, release_own, revoke, proto_err;
    // first requester at or above rr_ptr, wrapping
    always_comb begin
        sel = rr_ptr;
        idx = rr_ptr;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = OWNER_W'((int'(rr_ptr) + i) % NUM_REQ);
            if (!found && bus.in_reqcyc[idx]) begin
                sel = idx;
                found = 1'b1;
            end
        end
    end
    assign nxt_owner = OWNER_W'((int'(owner) + 1) % NUM_REQ);
    assign release_own = !(bus.in_reqcyc[owner] || bus.in_bus_busy[owner]) || revoke;
    always_comb begin
        state_n = state;
        grant_n = grant;
        owner_n = owner;
        rr_n = rr_ptr;
        case (state)
            IDLE: if (found) begin
                state_n = OWNED;
                grant_n = NUM_REQ'(1) << sel;
                owner_n = sel;
            end
            OWNED: if (release_own) begin
                state_n = TURNAROUND;
                grant_n = '0;
                rr_n = nxt_owner;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            grant <= '0;
            owner <= '0;
            rr_ptr <= '0;
            proto_err <= 1'b0;
        end else begin
            state <= state_n;
            grant <= grant_n;
            owner <= owner_n;
            rr_ptr <= rr_n;
            proto_err <= proto_err | (|(bus.in_bus_busy & ~grant));
        end
    end
`ifdef ARB_WATCHDOG_EN
    localparam int WD_W = $clog2(MAX_HOLD + 1);
    logic [WD_W-1:0] wd_cnt;
    logic timeout_err;
    // count reaching MAX_HOLD-1 at an edge means this is the MAX_HOLD-th owned cycle
    assign revoke = wd_cnt == WD_W'(MAX_HOLD - 1);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt <= '0;
            timeout_err <= 1'b0;
        end else begin
            wd_cnt <= state == OWNED ? wd_cnt + 1'b1 : '0;
            timeout_err <= timeout_err | (state == OWNED && revoke);
        end
    end
    assign bus.out_timeout_err = timeout_err;
`else
    assign revoke = 1'b0;
    assign bus.out_timeout_err = 1'b0;
`endif
    assign bus.out_grant = grant;
    assign bus.out_owner = owner;
    assign bus.out_owner_valid = |grant;
    assign bus.out_bus_busy = bus.in_bus_busy[owner] & (|grant);
    assign bus.out_proto_err = proto_err;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed vectors against hand-derived grant sequences
module tb_mem_bus_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;
    mem_bus_arbiter_if #(.NUM_REQ(4)) bus();
    mem_bus_arbiter #(.NUM_REQ(4), .MAX_HOLD(8)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic nxt;
        @(negedge clk);
    endtask
    task automatic do_reset;
        reset = 1'b1;
        bus.in_reqcyc = '0;
        bus.in_bus_busy = '0;
        nxt;
        reset = 1'b0;
        nxt;
    endtask
    initial begin
        bus.in_reqcyc = '0;
        bus.in_bus_busy = '0;
        nxt;
        nxt;
        check("rst_grant", bus.out_grant, 0);
        check("rst_owner", bus.out_owner, 0);
        check("rst_valid", bus.out_owner_valid, 0);
        check("rst_proto", bus.out_proto_err, 0);
        check("rst_tmo", bus.out_timeout_err, 0);
        reset = 1'b0;
        bus.in_reqcyc = 4'b0010;
        #1 check("lat_before", bus.out_grant, 0);
        nxt;
        check("lat_grant", bus.out_grant, 4'b0010);
        check("lat_owner", bus.out_owner, 1);
        check("lat_valid", bus.out_owner_valid, 1);
        reset = 1'b1;
        #1 check("async_grant", bus.out_grant, 0);
        check("async_valid", bus.out_owner_valid, 0);
        do_reset;
        bus.in_reqcyc = 4'b1111;
        nxt;
        for (int k = 0; k < 5; k++) begin
            automatic int o = k % 4;
            check("rr_grant", bus.out_grant, 4'b0001 << o);
            check("rr_owner", bus.out_owner, o);
            nxt;
            check("rr_hold", bus.out_grant, 4'b0001 << o);
            nxt;
            bus.in_reqcyc[o] = 1'b0;
            nxt;
            check("rr_turn", bus.out_grant, 0);
            if (k < 4) bus.in_reqcyc[o] = 1'b1;
            else bus.in_reqcyc = '0;
            nxt;
            check("rr_idle", bus.out_grant, 0);
            nxt;
        end
        do_reset;
        bus.in_reqcyc = 4'b0100;
        nxt;
        check("busy_grant", bus.out_grant, 4'b0100);
        check("busy_owner", bus.out_owner, 2);
        bus.in_bus_busy = 4'b0100;
        #1 check("busy_out_hi", bus.out_bus_busy, 1);
        nxt;
        bus.in_reqcyc = '0;
        for (int i = 0; i < 5; i++) begin
            nxt;
            check("busy_hold", bus.out_grant, 4'b0100);
            check("busy_track", bus.out_bus_busy, 1);
        end
        bus.in_bus_busy = '0;
        #1 check("busy_out_lo", bus.out_bus_busy, 0);
        nxt;
        check("busy_turn", bus.out_grant, 0);
        check("busy_owner_kept", bus.out_owner, 2);
        check("busy_valid", bus.out_owner_valid, 0);
        check("busy_proto", bus.out_proto_err, 0);
        do_reset;
        bus.in_reqcyc = 4'b0001;
        nxt;
        check("pe_grant", bus.out_grant, 4'b0001);
        bus.in_bus_busy = 4'b1000;
        #1 check("pe_busbusy", bus.out_bus_busy, 0);
        nxt;
        check("pe_set", bus.out_proto_err, 1);
        check("pe_grant_kept", bus.out_grant, 4'b0001);
        bus.in_bus_busy = '0;
        nxt;
        check("pe_sticky", bus.out_proto_err, 1);
        check("pe_grant_still", bus.out_grant, 4'b0001);
        bus.in_reqcyc = '0;
        nxt;
        nxt;
        nxt;
        check("pe_sticky_idle", bus.out_proto_err, 1);
        do_reset;
        bus.in_reqcyc = 4'b0010;
        nxt;
        check("rel_grant1", bus.out_grant, 4'b0010);
        bus.in_reqcyc = 4'b1010;
        nxt;
        check("rel_hold1", bus.out_grant, 4'b0010);
        bus.in_reqcyc = 4'b1000;
        nxt;
        check("rel_turn", bus.out_grant, 0);
        bus.in_reqcyc = 4'b1010;
        nxt;
        check("rel_idle", bus.out_grant, 0);
        nxt;
        check("rel_grant3", bus.out_grant, 4'b1000);
        check("rel_owner3", bus.out_owner, 3);
`ifdef ARB_WATCHDOG_EN
        do_reset;
        bus.in_reqcyc = 4'b0011;
        nxt;
        check("wd_grant", bus.out_grant, 4'b0001);
        for (int i = 1; i < 8; i++) begin
            nxt;
            check("wd_hold", bus.out_grant, 4'b0001);
        end
        check("wd_tmo_lo", bus.out_timeout_err, 0);
        nxt;
        check("wd_revoke", bus.out_grant, 0);
        check("wd_tmo", bus.out_timeout_err, 1);
        nxt;
        nxt;
        check("wd_next", bus.out_grant, 4'b0010);
        check("wd_tmo_sticky", bus.out_timeout_err, 1);
`else
        check("tmo_tied", bus.out_timeout_err, 0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
